// File: rtl/snake_pkg.sv
// ----------------------------------------------------------------------------
// snake_pkg: shared direction/state types and constants for snake_motion.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package snake_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_UP    = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_MOVE  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DEAD  = 2'b11
    } state_e;

    localparam logic [15:0] HEAD_MARK = 16'h0001;

    // Opposite directions differ only in bit 1 (right/left, down/up).
    function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
        return (a ^ b) == 2'b10;
    endfunction

endpackage

`default_nettype wire

// File: rtl/snake_dir_fifo.sv
// ----------------------------------------------------------------------------
// snake_dir_fifo: 2-entry direction queue; exposes oldest and newest entries.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module snake_dir_fifo (
    input  logic       clk_1,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [1:0] din,
    output logic [1:0] front,
    output logic [1:0] tail,
    output logic       empty
);

    logic [1:0] ent0_q, ent0_d;
    logic [1:0] ent1_q, ent1_d;
    logic [1:0] count_q, count_d;
    logic       w_do_push;
    logic       w_do_pop;

    always_comb begin
        ent0_d    = ent0_q;
        ent1_d    = ent1_q;
        count_d   = count_q;
        w_do_pop  = pop && (count_q != 2'd0);
        // A simultaneous pop frees a slot, so a push into a full queue still lands.
        w_do_push = push && ((count_q != 2'd2) || w_do_pop);
        case ({w_do_push, w_do_pop})
            2'b10: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd0) ent0_d = din;
                else                 ent1_d = din;
            end
            2'b01: begin
                count_d = count_q - 2'd1;
                ent0_d  = ent1_q;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    ent0_d = din;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            ent0_q  <= 2'b00;
            ent1_q  <= 2'b00;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign front = ent0_q;
    assign tail  = (count_q == 2'd2) ? ent1_q : ent0_q;
    assign empty = (count_q == 2'd0);

endmodule

`default_nettype wire

// File: rtl/snake_motion.sv
// ----------------------------------------------------------------------------
// snake_motion: snake head movement FSM with grid write, food and collision.
// Macro SNAKE_WRAP_EN: borders wrap around instead of killing the snake.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module snake_motion #(
    parameter int GRID_MAX = 29,
    parameter int INIT_X   = 3,
    parameter int INIT_Y   = 3,
    parameter int INIT_LEN = 3,
    parameter int MAX_LEN  = 784
) (
    input  logic        clk_1,
    input  logic        rst,
    input  logic        step,
    input  logic        dir_valid,
    input  logic [1:0]  dir_code,
    input  logic [4:0]  food_x,
    input  logic [4:0]  food_y,
    input  logic        cell_ack,
    output logic        cell_req,
    output logic [11:0] cell_addr,
    output logic [15:0] cell_wdata,
    output logic [1:0]  mov_dir,
    output logic [4:0]  head_x,
    output logic [4:0]  head_y,
    output logic [9:0]  length,
    output logic        food_eaten,
    output logic        alive,
    output logic        overrun
);

    import snake_pkg::*;

    localparam logic [4:0] c_grid_max = 5'(GRID_MAX);
    localparam logic [4:0] c_init_x   = 5'(INIT_X);
    localparam logic [4:0] c_init_y   = 5'(INIT_Y);
    localparam logic [9:0] c_init_len = 10'(INIT_LEN);
    localparam logic [9:0] c_max_len  = 10'(MAX_LEN);

    state_e     state_q, state_d;
    dir_e       mov_dir_q, mov_dir_d;
    logic [4:0] head_x_q, head_x_d;
    logic [4:0] head_y_q, head_y_d;
    logic [9:0] length_q, length_d;
    logic       alive_q, alive_d;
    logic       step_pending_q, step_pending_d;
    logic       overrun_q, overrun_d;

    logic [4:0] w_raw_x, w_raw_y;
    logic [4:0] w_next_x, w_next_y;
    logic       w_hit_border;
    logic       w_food_hit;
    logic       w_go;
    logic       w_fifo_push, w_fifo_pop, w_fifo_empty;
    logic [1:0] w_fifo_front, w_fifo_tail, w_dir_ref;

    snake_dir_fifo u_dir_fifo (
        .clk_1 (clk_1),
        .rst   (rst),
        .push  (w_fifo_push),
        .pop   (w_fifo_pop),
        .din   (dir_code),
        .front (w_fifo_front),
        .tail  (w_fifo_tail),
        .empty (w_fifo_empty)
    );

    // New requests are filtered against the direction the snake will be moving in last.
    assign w_dir_ref   = w_fifo_empty ? mov_dir_q : w_fifo_tail;
    assign w_fifo_push = dir_valid && (state_q != ST_DEAD) &&
                         (dir_code != w_dir_ref) && !is_reverse(dir_code, w_dir_ref);
    assign w_go        = (state_q == ST_RUN) && (step || step_pending_q);
    assign w_fifo_pop  = w_go && !w_fifo_empty;

    always_comb begin
        w_raw_x = head_x_q;
        w_raw_y = head_y_q;
        case (mov_dir_q)
            DIR_RIGHT: w_raw_x = head_x_q + 5'd1;
            DIR_DOWN:  w_raw_y = head_y_q + 5'd1;
            DIR_LEFT:  w_raw_x = head_x_q - 5'd1;
            default:   w_raw_y = head_y_q - 5'd1;
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign w_next_x     = (w_raw_x == 5'd0) ? (c_grid_max - 5'd1) :
                          (w_raw_x == c_grid_max) ? 5'd1 : w_raw_x;
    assign w_next_y     = (w_raw_y == 5'd0) ? (c_grid_max - 5'd1) :
                          (w_raw_y == c_grid_max) ? 5'd1 : w_raw_y;
    assign w_hit_border = 1'b0;
`else
    assign w_next_x     = w_raw_x;
    assign w_next_y     = w_raw_y;
    assign w_hit_border = (w_raw_x == 5'd0) || (w_raw_x == c_grid_max) ||
                          (w_raw_y == 5'd0) || (w_raw_y == c_grid_max);
`endif

    assign w_food_hit = (w_next_x == food_x) && (w_next_y == food_y) && !w_hit_border;

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (step || step_pending_q) state_d = ST_MOVE;
            ST_MOVE:  state_d = w_hit_border ? ST_DEAD : ST_WRITE;
            ST_WRITE: if (cell_ack) state_d = ST_RUN;
            default:  state_d = ST_DEAD;
        endcase
    end

    always_comb begin
        mov_dir_d      = mov_dir_q;
        head_x_d       = head_x_q;
        head_y_d       = head_y_q;
        length_d       = length_q;
        alive_d        = alive_q;
        step_pending_d = step_pending_q;
        overrun_d      = 1'b0;
        if (w_fifo_pop) mov_dir_d = dir_e'(w_fifo_front);
        if (state_q == ST_MOVE) begin
            head_x_d = w_next_x;
            head_y_d = w_next_y;
            if (w_hit_border)                              alive_d  = 1'b0;
            else if (w_food_hit && (length_q != c_max_len)) length_d = length_q + 10'd1;
        end
        // A step landing on the same RUN cycle as a pending one becomes the new pending step.
        case (state_q)
            ST_RUN: step_pending_d = step && step_pending_q;
            ST_MOVE, ST_WRITE: begin
                if (step) begin
                    if (step_pending_q) overrun_d      = 1'b1;
                    else                step_pending_d = 1'b1;
                end
            end
            default: step_pending_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            mov_dir_q      <= DIR_RIGHT;
            head_x_q       <= c_init_x;
            head_y_q       <= c_init_y;
            length_q       <= c_init_len;
            alive_q        <= 1'b1;
            step_pending_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            mov_dir_q      <= mov_dir_d;
            head_x_q       <= head_x_d;
            head_y_q       <= head_y_d;
            length_q       <= length_d;
            alive_q        <= alive_d;
            step_pending_q <= step_pending_d;
            overrun_q      <= overrun_d;
        end
    end

    always_comb begin
        cell_req   = (state_q == ST_WRITE);
        food_eaten = (state_q == ST_MOVE) && w_food_hit;
        cell_addr  = {1'b0, head_x_q, 1'b0, head_y_q};
        cell_wdata = HEAD_MARK;
        mov_dir    = mov_dir_q;
        head_x     = head_x_q;
        head_y     = head_y_q;
        length     = length_q;
        alive      = alive_q;
        overrun    = overrun_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_snake_motion.sv
// ----------------------------------------------------------------------------
// tb_snake_motion: scoreboard bench for snake_motion (either SNAKE_WRAP_EN build).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_snake_motion;

    localparam logic [1:0] c_right = 2'b00;
    localparam logic [1:0] c_down  = 2'b01;
    localparam logic [1:0] c_left  = 2'b10;
    localparam logic [1:0] c_up    = 2'b11;

    logic        clk_1 = 1'b0;
    logic        rst, step, dir_valid, cell_ack;
    logic [1:0]  dir_code;
    logic [4:0]  food_x, food_y;
    logic        cell_req, food_eaten, alive, overrun;
    logic [11:0] cell_addr;
    logic [15:0] cell_wdata;
    logic [1:0]  mov_dir;
    logic [4:0]  head_x, head_y;
    logic [9:0]  length;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [11:0] sb_q[$];
    logic [4:0]  mx, my;
    logic [9:0]  mlen;

    always #5 clk_1 = ~clk_1;

    snake_motion dut (
        .clk_1      (clk_1),
        .rst        (rst),
        .step       (step),
        .dir_valid  (dir_valid),
        .dir_code   (dir_code),
        .food_x     (food_x),
        .food_y     (food_y),
        .cell_ack   (cell_ack),
        .cell_req   (cell_req),
        .cell_addr  (cell_addr),
        .cell_wdata (cell_wdata),
        .mov_dir    (mov_dir),
        .head_x     (head_x),
        .head_y     (head_y),
        .length     (length),
        .food_eaten (food_eaten),
        .alive      (alive),
        .overrun    (overrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Completed grid writes are matched against expected head cells.
    always @(negedge clk_1) begin
        if (cell_req === 1'b1 && cell_ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_write", 32'(cell_addr), 32'hFFFF_FFFF);
            end else begin
                check_eq("sb_cell_addr", 32'(cell_addr), 32'(sb_q.pop_front()));
                check_eq("sb_cell_wdata", 32'(cell_wdata), 32'h1);
            end
        end
    end

    task automatic tick;
        @(posedge clk_1);
        #1;
    endtask

    task automatic do_reset;
        step = 1'b0; dir_valid = 1'b0; dir_code = 2'b00; cell_ack = 1'b0;
        rst = 1'b1;
        sb_q.delete();
        tick;
        tick;
        rst = 1'b0;
        mx = 5'd3; my = 5'd3; mlen = 10'd3;
        tick;
    endtask

    task automatic push_dir(input logic [1:0] d);
        dir_valid = 1'b1;
        dir_code  = d;
        tick;
        dir_valid = 1'b0;
    endtask

    // One complete move: expected direction and whether food is eaten are given by the caller.
    task automatic do_step(input logic [1:0] d, input logic eat);
        logic [4:0] nx, ny;
        logic       dead;
        nx = mx; ny = my;
        case (d)
            c_right: nx = mx + 5'd1;
            c_down:  ny = my + 5'd1;
            c_left:  nx = mx - 5'd1;
            default: ny = my - 5'd1;
        endcase
`ifdef SNAKE_WRAP_EN
        if (nx == 5'd0) nx = 5'd28; else if (nx == 5'd29) nx = 5'd1;
        if (ny == 5'd0) ny = 5'd28; else if (ny == 5'd29) ny = 5'd1;
        dead = 1'b0;
`else
        dead = (nx == 5'd0) || (nx == 5'd29) || (ny == 5'd0) || (ny == 5'd29);
`endif
        if (!dead) sb_q.push_back({1'b0, nx, 1'b0, ny});
        step = 1'b1;
        tick;
        step = 1'b0;
        check_eq("food_eaten", 32'(food_eaten), 32'(eat));
        tick;
        mx = nx; my = ny;
        if (eat) mlen = mlen + 10'd1;
        check_eq("head_x", 32'(head_x), 32'(mx));
        check_eq("head_y", 32'(head_y), 32'(my));
        check_eq("mov_dir", 32'(mov_dir), 32'(d));
        check_eq("length", 32'(length), 32'(mlen));
        check_eq("alive", 32'(alive), 32'(!dead));
        check_eq("cell_req_latency", 32'(cell_req), 32'(!dead));
        if (!dead) begin
            cell_ack = 1'b1;
            tick;
            cell_ack = 1'b0;
            check_eq("cell_req_fall", 32'(cell_req), 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation bound reached");
        $fatal(1, "timeout");
    end

    initial begin
        food_x = 5'd20; food_y = 5'd20;
        do_reset;
        check_eq("rst_head_x", 32'(head_x), 32'd3);
        check_eq("rst_head_y", 32'(head_y), 32'd3);
        check_eq("rst_length", 32'(length), 32'd3);
        check_eq("rst_alive", 32'(alive), 32'd1);
        check_eq("rst_mov_dir", 32'(mov_dir), 32'd0);
        check_eq("rst_cell_req", 32'(cell_req), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);

        // First move eats food at (4,3); grid write lands at 12'h103.
        food_x = 5'd4; food_y = 5'd3;
        do_step(c_right, 1'b1);
        check_eq("food_pulse_end", 32'(food_eaten), 32'd0);
        food_x = 5'd20; food_y = 5'd20;

        // Reverse request discarded, down accepted.
        do_reset;
        push_dir(c_left);
        push_dir(c_down);
        do_step(c_down, 1'b0);
        do_step(c_down, 1'b0);

        // Third request into a full queue is discarded.
        do_reset;
        push_dir(c_down);
        push_dir(c_left);
        push_dir(c_up);
        do_step(c_down, 1'b0);
        do_step(c_left, 1'b0);
        do_step(c_left, 1'b0);

        // Ack withheld: second step pends, third overruns; exactly two moves happen.
        do_reset;
        sb_q.push_back({1'b0, 5'd4, 1'b0, 5'd3});
        sb_q.push_back({1'b0, 5'd5, 1'b0, 5'd3});
        step = 1'b1;
        tick;
        tick;
        tick;
        step = 1'b0;
        check_eq("overrun_pulse", 32'(overrun), 32'd1);
        tick;
        check_eq("overrun_clear", 32'(overrun), 32'd0);
        check_eq("held_req", 32'(cell_req), 32'd1);
        cell_ack = 1'b1;
        tick;
        cell_ack = 1'b0;
        tick;
        tick;
        check_eq("pend_req", 32'(cell_req), 32'd1);
        check_eq("pend_head_x", 32'(head_x), 32'd5);
        cell_ack = 1'b1;
        tick;
        cell_ack = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        check_eq("no_extra_move_x", 32'(head_x), 32'd5);
        check_eq("no_extra_req", 32'(cell_req), 32'd0);

        // Reset in the middle of a write.
        do_reset;
        step = 1'b1;
        tick;
        step = 1'b0;
        tick;
        check_eq("mid_write_req", 32'(cell_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_req", 32'(cell_req), 32'd0);
        check_eq("async_rst_head_x", 32'(head_x), 32'd3);
        check_eq("async_rst_head_y", 32'(head_y), 32'd3);
        sb_q.delete();
        do_reset;

        // Drive to (28,5), then move right onto the border.
        push_dir(c_down);
        do_step(c_down, 1'b0);
        do_step(c_down, 1'b0);
        push_dir(c_right);
        for (int i = 0; i < 25; i++) do_step(c_right, 1'b0);
        check_eq("edge_head_x", 32'(head_x), 32'd28);
        do_step(c_right, 1'b0);
`ifdef SNAKE_WRAP_EN
        check_eq("wrap_head_x", 32'(head_x), 32'd1);
`else
        step = 1'b1;
        tick;
        step = 1'b0;
        tick;
        tick;
        check_eq("dead_no_overrun", 32'(overrun), 32'd0);
        check_eq("dead_no_req", 32'(cell_req), 32'd0);
        check_eq("dead_alive", 32'(alive), 32'd0);
`endif

        tick;
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
